// File: rtl/sm_pipe_ctrl_pkg.sv
// Shared types and control-vector constants for the schoolMIPS pipeline stall/flush scheduler.
package sm_pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    localparam int FD = 0;
    localparam int DE = 1;
    localparam int EM = 2;
    localparam int MW = 3;

    typedef struct packed {
        logic       pc_we;
        logic [3:0] we;
        logic [3:0] clr_n;
    } ctrl_t;

    localparam ctrl_t RESET_CTRL = '{pc_we: 1'b0, we: 4'b1111, clr_n: 4'b0000};
    localparam ctrl_t NORMAL     = '{pc_we: 1'b1, we: 4'b1111, clr_n: 4'b1111};
    localparam ctrl_t MEM_STALL  = '{pc_we: 1'b0, we: 4'b1000, clr_n: 4'b0111};
    localparam ctrl_t MDU_STALL  = '{pc_we: 1'b0, we: 4'b1100, clr_n: 4'b1011};
    localparam ctrl_t FLUSH      = '{pc_we: 1'b1, we: 4'b1111, clr_n: 4'b1100};
    localparam ctrl_t LOAD_USE   = '{pc_we: 1'b0, we: 4'b1111, clr_n: 4'b1101};

    // Clear-able width helper: a latency of 1 would otherwise give a zero-width counter.
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/sm_pipe_mdu_timer.sv
// Loadable down-counter that saturates at zero; tracks remaining MDU stall cycles.
module sm_pipe_mdu_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_cnt,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sm_pipe_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: PC enable, per-boundary we/clr_n,
// MDU hold sequencing and a saturating stall-cycle counter.
//
// state    | meaning
// RUN      | normal issue; mem stall, MDU start, branch flush, load-use arbitrated
// MDU_WAIT | multi-cycle MDU op held in E; released when the timer reaches zero
module sm_pipe_ctrl
    import sm_pipe_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hz_load_use,
    input  logic             i_br_taken,
    input  logic             i_mdu_start,
    input  logic             i_mem_req,
    input  logic             i_mem_ack,
    output logic             o_pc_we,
    output logic [3:0]       o_stage_we,
    output logic [3:0]       o_stage_clr_n,
    output logic             o_mdu_done,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int MDU_W = cnt_width(MDU_LAT);
    localparam logic [MDU_W-1:0] MDU_LOAD = MDU_W'(MDU_LAT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    ctrl_t            w_ctrl;
    logic             w_mdu_done;
    logic             w_mem_stall;
    logic             w_mdu_load;
    logic             w_mdu_zero;
    logic [MDU_W-1:0] w_mdu_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_mem_stall = i_mem_req & ~i_mem_ack;
    assign w_mdu_load  = ~rst & (r_state == RUN) & i_mdu_start & ~w_mem_stall;

    sm_pipe_mdu_timer #(
        .W (MDU_W)
    ) u_mdu_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_mdu_load),
        .i_load_val (MDU_LOAD),
        .o_cnt      (w_mdu_cnt),
        .o_zero     (w_mdu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (i_mdu_start && !w_mem_stall) begin
                    w_state_nxt = MDU_WAIT;
                end
            end
            MDU_WAIT: begin
                if (w_mdu_zero && !w_mem_stall) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // Mem stall outranks everything, including the MDU release cycle.
    always_comb begin
        w_ctrl     = NORMAL;
        w_mdu_done = 1'b0;
        if (rst) begin
            w_ctrl = RESET_CTRL;
        end else if (w_mem_stall) begin
            w_ctrl = MEM_STALL;
        end else begin
            case (r_state)
                RUN: begin
                    if (i_mdu_start) begin
                        w_ctrl = MDU_STALL;
                    end else if (i_br_taken) begin
                        w_ctrl = FLUSH;
                    end else if (i_hz_load_use) begin
                        w_ctrl = LOAD_USE;
                    end
                end
                MDU_WAIT: begin
                    if (!w_mdu_zero) begin
                        w_ctrl = MDU_STALL;
                    end else begin
                        w_mdu_done = 1'b1;
                    end
                end
                default: w_ctrl = NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!w_ctrl.pc_we && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_pc_we       = w_ctrl.pc_we;
    assign o_stage_we    = w_ctrl.we;
    assign o_stage_clr_n = w_ctrl.clr_n;
    assign o_mdu_done    = w_mdu_done;
    assign o_stall_cnt   = r_stall_cnt;

endmodule
